// File: rtl/debounce_strobe.sv
// debounce_strobe: synchronizes a raw asynchronous input, qualifies each candidate
// transition with a stability counter, and produces a clean registered level (d),
// a one-cycle registered strobe (e) and a qualification-in-progress flag (busy).
// Optional feature macro: DEBOUNCE_BOTH_EDGES_EN (strobe on falling transitions too).
module debounce_strobe #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 10,
  parameter int unsigned CNT_W       = 4,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic d,
  output logic e,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
    $error("debounce_strobe: SYNC_STAGES must be in 2..4");
  end
  if ((STABLE_CNT < 1) || (64'(STABLE_CNT) > (64'd1 << CNT_W))) begin : g_bad_cnt
    $error("debounce_strobe: STABLE_CNT must be in 1..2**CNT_W");
  end

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   d_q, d_d;
  logic                   e_q, e_d;
  logic                   busy_q, busy_d;
  logic                   sync_out;
  logic                   diff;
  logic                   strobe;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign diff     = (sync_out != d_q);

`ifdef DEBOUNCE_BOTH_EDGES_EN
  assign strobe = 1'b1;
`else
  assign strobe = sync_out;
`endif

  // Next-state: synchronizer shift, stability counting and qualification.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    e_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (diff) begin
          if (STABLE_CNT == 1) begin
            d_d = sync_out;
            e_d = strobe;
          end else begin
            state_d = CHECK;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (!diff) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          d_d     = sync_out;
          e_d     = strobe;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CHECK);
  end

  // State and registered outputs; async reset discards any candidate in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= RST_VAL;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
    end
  end

  assign d    = d_q;
  assign e    = e_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_strobe.sv
// Directed testbench for debounce_strobe: default build plus a STABLE_CNT=1 instance.
module tb_debounce_strobe;

  logic clk;
  logic rst_n;
  logic din;
  logic d, e, busy;
  logic d1, e1, busy1;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  debounce_strobe #(
    .SYNC_STAGES(2),
    .STABLE_CNT (10),
    .CNT_W      (4),
    .RST_VAL    (1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .d    (d),
    .e    (e),
    .busy (busy)
  );

  debounce_strobe #(
    .SYNC_STAGES(2),
    .STABLE_CNT (1),
    .CNT_W      (4),
    .RST_VAL    (1'b0)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .d    (d1),
    .e    (e1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic settle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset held with din=1, released at 12 ns with din=0: outputs stay quiet.
  task automatic test_reset();
    rst_n = 1'b0;
    din   = 1'b1;
    #6;
    total_cnt++;
    if ({d, e, busy} !== 3'b000) $display("FAIL reset_hold: got d/e/busy=%b need 000", {d, e, busy});
    else pass_cnt++;
    #6;
    rst_n = 1'b1;
    din   = 1'b0;
    for (int unsigned n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({d, e, busy} !== 3'b000) $display("FAIL reset_quiet edge %0d: got d/e/busy=%b need 000", n, {d, e, busy});
      else pass_cnt++;
    end
  endtask

  // Rising edge held: busy edges 3..11, d/e at edge 12, e drops at 13.
  task automatic test_rise();
    din = 1'b1;
    for (int unsigned n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({d, e, busy} !== {(n >= 12), (n == 12), (n >= 3 && n <= 11)})
        $display("FAIL rise edge %0d: got d/e/busy=%b need %b", n, {d, e, busy},
                 {(n >= 12), (n == 12), (n >= 3 && n <= 11)});
      else pass_cnt++;
    end
  endtask

  // Falling edge from d=1: d drops at edge 12, e only with both-edges build.
  task automatic test_fall();
    logic exp_e;
    din = 1'b0;
    for (int unsigned n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
`ifdef DEBOUNCE_BOTH_EDGES_EN
      exp_e = (n == 12);
`else
      exp_e = 1'b0;
`endif
      total_cnt++;
      if ({d, e, busy} !== {(n < 12), exp_e, (n >= 3 && n <= 11)})
        $display("FAIL fall edge %0d: got d/e/busy=%b need %b", n, {d, e, busy},
                 {(n < 12), exp_e, (n >= 3 && n <= 11)});
      else pass_cnt++;
    end
  endtask

  // Five-cycle glitch: busy pulses edges 3..7, no strobe, counter cleared.
  task automatic test_glitch();
    din = 1'b1;
    for (int unsigned n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) din = 1'b0;
      total_cnt++;
      if ({d, e, busy} !== {1'b0, 1'b0, (n >= 3 && n <= 7)})
        $display("FAIL glitch edge %0d: got d/e/busy=%b need %b", n, {d, e, busy},
                 {1'b0, 1'b0, (n >= 3 && n <= 7)});
      else pass_cnt++;
    end
    total_cnt++;
    if (dut.cnt_q !== 4'd0) $display("FAIL glitch_cnt: got %0d need 0", dut.cnt_q);
    else pass_cnt++;
  endtask

  // Reset mid-qualification discards the candidate; full latency restarts.
  task automatic test_reset_mid();
    din = 1'b1;
    settle(8);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b need 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({d, e, busy} !== 3'b000) $display("FAIL rmid_async: got d/e/busy=%b need 000", {d, e, busy});
    else pass_cnt++;
    settle(2);
    rst_n = 1'b1;
    for (int unsigned n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({d, e, busy} !== {(n >= 12), (n == 12), (n >= 3 && n <= 11)})
        $display("FAIL rmid_restart edge %0d: got d/e/busy=%b need %b", n, {d, e, busy},
                 {(n >= 12), (n == 12), (n >= 3 && n <= 11)});
      else pass_cnt++;
    end
    din = 1'b0;
    settle(16);
    total_cnt++;
    if ({d, busy} !== 2'b00) $display("FAIL rmid_return: got d/busy=%b need 00", {d, busy});
    else pass_cnt++;
  endtask

  // Pulse length boundary: 9 cycles at sync_out rejected, 10 accepted.
  task automatic test_boundary();
    din = 1'b1;
    for (int unsigned n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      if (n == 9) din = 1'b0;
      total_cnt++;
      if ({d, e} !== 2'b00) $display("FAIL bound9 edge %0d: got d/e=%b need 00", n, {d, e});
      else pass_cnt++;
    end
    settle(4);
    din = 1'b1;
    for (int unsigned n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) din = 1'b0;
      total_cnt++;
      if ({d, e} !== {(n >= 12), (n == 12)})
        $display("FAIL bound10 edge %0d: got d/e=%b need %b", n, {d, e}, {(n >= 12), (n == 12)});
      else pass_cnt++;
    end
    settle(20);
    total_cnt++;
    if ({d, busy} !== 2'b00) $display("FAIL bound_return: got d/busy=%b need 00", {d, busy});
    else pass_cnt++;
  endtask

  // STABLE_CNT=1 instance: d and e at edge 3, never busy.
  task automatic test_stable_one();
    total_cnt++;
    if ({d1, busy1} !== 2'b00) $display("FAIL one_start: got d1/busy1=%b need 00", {d1, busy1});
    else pass_cnt++;
    din = 1'b1;
    for (int unsigned n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({d1, e1, busy1} !== {(n >= 3), (n == 3), 1'b0})
        $display("FAIL one edge %0d: got d1/e1/busy1=%b need %b", n, {d1, e1, busy1},
                 {(n >= 3), (n == 3), 1'b0});
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    din       = 1'b1;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_reset_mid();
    test_boundary();
    test_stable_one();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
